load_unit: RTL and testbench

- Read-side counterpart of the store byte-lane path.
- Accepts one load request from the execute stage (funct3, effective address, destination register).
- Issues a word-aligned read to data memory over a req/gnt + rvalid handshake.
- Selects the addressed byte or halfword lane, sign- or zero-extends it, and returns the result to writeback through a valid/ready handshake. One load is outstanding at a time.

---
 rtl/load_unit_pkg.sv | 31 +++
 rtl/load_align.sv | 35 +++
 rtl/load_unit.sv | 143 ++++++++++++++
 tb/tb_load_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/load_unit_pkg.sv
// Shared load/store constants, FSM state encodings and the access-legality helper.
package load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Misaligned halfword/word or an undefined load funct3.
  function automatic logic ld_bad_access(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = (off != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of a fetched word.
module load_align
  import load_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    case (offset)
      2'd0:    byte_c = word[7:0];
      2'd1:    byte_c = word[15:8];
      2'd2:    byte_c = word[23:16];
      default: byte_c = word[31:24];
    endcase
    half_c = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   data = {{(DATA_W-8){byte_c[7]}}, byte_c};
      F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_c};
      F3_LH:   data = {{(DATA_W-16){half_c[15]}}, half_c};
      F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_c};
      F3_LW:   data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Single-outstanding load unit: word read over req/gnt + rvalid, lane-aligned result to writeback.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [2:0]        ld_funct3,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [RD_W-1:0]   ld_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_err
);

  logic [1:0]        state, state_n;
  logic [2:0]        f3_q, f3_n;
  logic [1:0]        off_q, off_n;
  logic [RD_W-1:0]   rd_q, rd_n;
  logic              mem_req_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic              wb_valid_n;
  logic [DATA_W-1:0] wb_data_n;
  logic [RD_W-1:0]   wb_rd_n;
  logic              wb_err_n;
  logic [DATA_W-1:0] aligned_c;
  logic              ld_err_c;

  load_align #(.DATA_W(DATA_W)) u_align (
    .funct3 (f3_q),
    .offset (off_q),
    .word   (mem_rdata),
    .data   (aligned_c)
  );

  assign ld_ready = (state == S_IDLE);
  assign ld_err_c = ld_bad_access(ld_funct3, ld_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      f3_q     <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      wb_err   <= 1'b0;
    end else begin
      state    <= state_n;
      f3_q     <= f3_n;
      off_q    <= off_n;
      rd_q     <= rd_n;
      mem_req  <= mem_req_n;
      mem_addr <= mem_addr_n;
      wb_valid <= wb_valid_n;
      wb_data  <= wb_data_n;
      wb_rd    <= wb_rd_n;
      wb_err   <= wb_err_n;
    end
  end

  // Next state and next registered outputs; rvalid only matters in REQ/WAIT.
  always_comb begin
    state_n    = state;
    f3_n       = f3_q;
    off_n      = off_q;
    rd_n       = rd_q;
    mem_req_n  = mem_req;
    mem_addr_n = mem_addr;
    wb_valid_n = wb_valid;
    wb_data_n  = wb_data;
    wb_rd_n    = wb_rd;
    wb_err_n   = wb_err;

    case (state)
      S_IDLE: begin
        if (ld_valid) begin
          f3_n  = ld_funct3;
          off_n = ld_addr[1:0];
          rd_n  = ld_rd;
          if (ld_err_c) begin
            state_n    = S_RESP;
            wb_valid_n = 1'b1;
            wb_err_n   = 1'b1;
            wb_data_n  = '0;
            wb_rd_n    = ld_rd;
          end else begin
            state_n    = S_REQ;
            mem_req_n  = 1'b1;
            mem_addr_n = {ld_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_n = 1'b0;
          if (mem_rvalid) begin
            state_n    = S_RESP;
            wb_valid_n = 1'b1;
            wb_data_n  = aligned_c;
            wb_rd_n    = rd_q;
            wb_err_n   = 1'b0;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_n    = S_RESP;
          wb_valid_n = 1'b1;
          wb_data_n  = aligned_c;
          wb_rd_n    = rd_q;
          wb_err_n   = 1'b0;
        end
      end
      S_RESP: begin
        if (wb_ready) begin
          state_n    = S_IDLE;
          wb_valid_n = 1'b0;
          wb_err_n   = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: lane alignment, error path, handshake timing, reset abandon.
module tb_load_unit;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  load_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_funct3  (ld_funct3),
    .ld_addr    (ld_addr),
    .ld_rd      (ld_rd),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_data    (wb_data),
    .wb_rd      (wb_rd),
    .wb_err     (wb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one load and play memory: grant after gnt_wait stalled cycles, rvalid with or after gnt.
  task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input int gnt_wait, input bit same_cyc,
                          input logic [31:0] word, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat, input int hold);
    int n;
    int stall;
    bit pend;
    bit saw_req;
    bit done;
    @(negedge clk);
    check({name, ":ld_ready"}, 32'(ld_ready), 32'd1);
    ld_valid  = 1'b1;
    ld_funct3 = f3;
    ld_addr   = addr;
    ld_rd     = rd;
    @(negedge clk);
    ld_valid = 1'b0;
    n = 1; stall = 0; pend = 0; saw_req = 0; done = 0;
    while (!done && n <= 40) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hDEAD_BEEF;
      if (wb_valid) begin
        done = 1;
      end else begin
        if (mem_req) begin
          saw_req = 1;
          check({name, ":mem_addr"}, mem_addr, {addr[31:2], 2'b00});
          if (stall == gnt_wait) begin
            mem_gnt = 1'b1;
            if (same_cyc) begin
              mem_rvalid = 1'b1;
              mem_rdata  = word;
            end else begin
              pend = 1;
            end
          end
          stall++;
        end else if (pend) begin
          mem_rvalid = 1'b1;
          mem_rdata  = word;
          pend = 0;
        end
        @(negedge clk);
        n++;
      end
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    check({name, ":wb_valid"}, 32'(wb_valid), 32'd1);
    check({name, ":latency"}, 32'(n), 32'(exp_lat));
    check({name, ":wb_data"}, wb_data, exp_data);
    check({name, ":wb_rd"}, 32'(wb_rd), 32'(rd));
    check({name, ":wb_err"}, 32'(wb_err), 32'(exp_err));
    check({name, ":mem_req_seen"}, 32'(saw_req), 32'(!exp_err));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, ":hold_valid"}, 32'(wb_valid), 32'd1);
      check({name, ":hold_data"}, wb_data, exp_data);
      check({name, ":hold_ld_ready"}, 32'(ld_ready), 32'd0);
    end
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    check({name, ":post_valid"}, 32'(wb_valid), 32'd0);
    check({name, ":post_err"}, 32'(wb_err), 32'd0);
    check({name, ":post_ld_ready"}, 32'(ld_ready), 32'd1);
    check({name, ":post_data_held"}, wb_data, exp_data);
  endtask

  initial begin
    clk        = 1'b0;
    rst_n      = 1'b0;
    ld_valid   = 1'b0;
    ld_funct3  = 3'b000;
    ld_addr    = 32'h0;
    ld_rd      = 5'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    wb_ready   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst:mem_req", 32'(mem_req), 32'd0);
    check("rst:mem_addr", mem_addr, 32'd0);
    check("rst:wb_valid", 32'(wb_valid), 32'd0);
    check("rst:wb_data", wb_data, 32'd0);
    check("rst:wb_rd", 32'(wb_rd), 32'd0);
    check("rst:wb_err", 32'(wb_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst:ld_ready", 32'(ld_ready), 32'd1);

    run_load("lb_1001",  3'b000, 32'h1001, 5'd1, 0, 0, 32'hAABBCCDD, 32'hFFFFFFCC, 1'b0, 3, 0);
    run_load("lbu_1003", 3'b100, 32'h1003, 5'd2, 0, 0, 32'hAABBCCDD, 32'h000000AA, 1'b0, 3, 0);
    run_load("lb_1000",  3'b000, 32'h1000, 5'd3, 0, 0, 32'hAABBCCDD, 32'hFFFFFFDD, 1'b0, 3, 0);
    run_load("lh_1002",  3'b001, 32'h1002, 5'd4, 0, 0, 32'hAABBCCDD, 32'hFFFFAABB, 1'b0, 3, 0);
    run_load("lhu_1000", 3'b101, 32'h1000, 5'd5, 0, 0, 32'hAABBCCDD, 32'h0000CCDD, 1'b0, 3, 0);
    run_load("lw_1000",  3'b010, 32'h1000, 5'd7, 0, 0, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0, 3, 0);
    run_load("lhu_3002", 3'b101, 32'h3002, 5'd9, 0, 0, 32'hF0F01234, 32'h0000F0F0, 1'b0, 3, 0);

    run_load("err_lw",   3'b010, 32'h1002, 5'd10, 0, 0, 32'hAABBCCDD, 32'h0, 1'b1, 1, 0);
    run_load("err_lh",   3'b001, 32'h1001, 5'd11, 0, 0, 32'hAABBCCDD, 32'h0, 1'b1, 1, 0);
    run_load("err_f3",   3'b011, 32'h1000, 5'd12, 0, 0, 32'hAABBCCDD, 32'h0, 1'b1, 1, 0);

    run_load("stall_gnt", 3'b100, 32'h2002, 5'd13, 3, 0, 32'h12345678, 32'h00000034, 1'b0, 6, 0);
    run_load("same_cyc",  3'b001, 32'h2000, 5'd14, 0, 1, 32'h00008001, 32'hFFFF8001, 1'b0, 2, 4);

    // Reset while waiting for read data, then a stray rvalid.
    @(negedge clk);
    ld_valid  = 1'b1;
    ld_funct3 = 3'b010;
    ld_addr   = 32'h4000;
    ld_rd     = 5'd3;
    @(negedge clk);
    ld_valid = 1'b0;
    mem_gnt  = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rstwait:mem_req", 32'(mem_req), 32'd0);
    check("rstwait:ld_ready", 32'(ld_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rstwait:wb_valid", 32'(wb_valid), 32'd0);
    check("rstwait:ld_ready", 32'(ld_ready), 32'd1);
    check("rstwait:mem_req_idle", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("rstwait:wb_valid_later", 32'(wb_valid), 32'd0);

    run_load("after_rst", 3'b010, 32'h5004, 5'd21, 0, 0, 32'hCAFE0001, 32'hCAFE0001, 1'b0, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
